// File: rtl/alu_issue_wb.sv
// Operand-issue and writeback stage around an external registered ALU.
// Decodes RV32I R/I ALU ops, reads/forwards operands, stalls on RAW hazards, writes results back.
module alu_issue_wb #(
    parameter bit         FWD_EN     = 1'b1,
    parameter logic [2:0] BUBBLE_SEL = 3'd7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    output logic [31:0] rs1_o,
    output logic [31:0] rs2_o,
    output logic [2:0]  sel_o,
    input  logic [31:0] alu_res,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        illegal
);

    localparam logic [6:0] OPC_R   = 7'b0110011;
    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] SEL_ADD = 3'd0;
    localparam logic [2:0] SEL_AND = 3'd1;
    localparam logic [2:0] SEL_XOR = 3'd2;
    localparam logic [2:0] SEL_SLL = 3'd3;
    localparam logic [2:0] SEL_SRA = 3'd4;
    localparam logic [2:0] SEL_SUB = 3'd5;

    logic [6:0]  opc_s;
    logic [4:0]  rd_s;
    logic [2:0]  f3_s;
    logic [4:0]  rs1_a_s;
    logic [4:0]  rs2_a_s;
    logic [6:0]  f7_s;
    logic [31:0] imm_s;

    logic        dec_legal_s;
    logic        dec_rtype_s;
    logic [2:0]  dec_sel_s;

    logic        wb_hit1_s;
    logic        wb_hit2_s;
    logic        ex_hit1_s;
    logic        ex_hit2_s;
    logic        hazard_s;
    logic        accept_s;

    logic [31:0] src1_val_s;
    logic [31:0] src2_val_s;
    logic [31:0] opb_raw_s;
    logic [31:0] opb_s;

    logic [31:0] ex_a_d,   ex_a_q;
    logic [31:0] ex_b_d,   ex_b_q;
    logic [2:0]  ex_sel_d, ex_sel_q;
    logic [4:0]  ex_rd_d,  ex_rd_q;
    logic        ex_we_d,  ex_we_q;
    logic        ill_d,    ill_q;
    logic        wb_valid_d, wb_valid_q;
    logic [4:0]  wb_rd_d,    wb_rd_q;

    logic [31:0] rf_q [32];

    assign opc_s   = instr[6:0];
    assign rd_s    = instr[11:7];
    assign f3_s    = instr[14:12];
    assign rs1_a_s = instr[19:15];
    assign rs2_a_s = instr[24:20];
    assign f7_s    = instr[31:25];
    assign imm_s   = {{20{instr[31]}}, instr[31:20]};

    // Decode: legality, operand-B source and ALU op select
    always_comb begin
        dec_legal_s = 1'b0;
        dec_rtype_s = 1'b0;
        dec_sel_s   = BUBBLE_SEL;
        case (opc_s)
            OPC_R: begin
                dec_rtype_s = 1'b1;
                case (f3_s)
                    3'b000: begin
                        if (f7_s == F7_ZERO) begin
                            dec_legal_s = 1'b1;
                            dec_sel_s   = SEL_ADD;
                        end else if (f7_s == F7_ALT) begin
                            dec_legal_s = 1'b1;
                            dec_sel_s   = SEL_SUB;
                        end else begin
                            dec_legal_s = 1'b0;
                        end
                    end
                    3'b111: begin
                        dec_legal_s = (f7_s == F7_ZERO);
                        dec_sel_s   = SEL_AND;
                    end
                    3'b100: begin
                        dec_legal_s = (f7_s == F7_ZERO);
                        dec_sel_s   = SEL_XOR;
                    end
                    3'b001: begin
                        dec_legal_s = (f7_s == F7_ZERO);
                        dec_sel_s   = SEL_SLL;
                    end
                    3'b101: begin
                        dec_legal_s = (f7_s == F7_ALT);
                        dec_sel_s   = SEL_SRA;
                    end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            OPC_I: begin
                case (f3_s)
                    3'b000: begin
                        dec_legal_s = 1'b1;
                        dec_sel_s   = SEL_ADD;
                    end
                    3'b111: begin
                        dec_legal_s = 1'b1;
                        dec_sel_s   = SEL_AND;
                    end
                    3'b100: begin
                        dec_legal_s = 1'b1;
                        dec_sel_s   = SEL_XOR;
                    end
                    3'b001: begin
                        dec_legal_s = (f7_s == F7_ZERO);
                        dec_sel_s   = SEL_SLL;
                    end
                    3'b101: begin
                        dec_legal_s = (f7_s == F7_ALT);
                        dec_sel_s   = SEL_SRA;
                    end
                    default: dec_legal_s = 1'b0;
                endcase
            end
            default: dec_legal_s = 1'b0;
        endcase
        if (!dec_legal_s) begin
            dec_sel_s = BUBBLE_SEL;
        end else begin
            dec_sel_s = dec_sel_s;
        end
    end

    assign wb_hit1_s = wb_valid_q && (rs1_a_s != 5'd0) && (rs1_a_s == wb_rd_q);
    assign wb_hit2_s = wb_valid_q && (rs2_a_s != 5'd0) && (rs2_a_s == wb_rd_q);
    assign ex_hit1_s = ex_we_q && (rs1_a_s != 5'd0) && (rs1_a_s == ex_rd_q);
    assign ex_hit2_s = ex_we_q && (rs2_a_s != 5'd0) && (rs2_a_s == ex_rd_q);

    // An EX match always stalls; a WB match stalls only when forwarding is disabled
    always_comb begin
        hazard_s = 1'b0;
        if (dec_legal_s) begin
            hazard_s = ex_hit1_s || (dec_rtype_s && ex_hit2_s) ||
                       (!FWD_EN && (wb_hit1_s || (dec_rtype_s && wb_hit2_s)));
        end else begin
            hazard_s = 1'b0;
        end
    end

    assign in_ready = !(in_valid && hazard_s);
    assign accept_s = in_valid && in_ready;

    // Source 1 read: the WB value wins over the regfile so a same-cycle write is never missed
    always_comb begin
        src1_val_s = 32'd0;
        if (rs1_a_s == 5'd0) begin
            src1_val_s = 32'd0;
        end else if (FWD_EN && wb_hit1_s) begin
            src1_val_s = alu_res;
        end else begin
            src1_val_s = rf_q[rs1_a_s];
        end
    end

    // Source 2 read, same priority as source 1
    always_comb begin
        src2_val_s = 32'd0;
        if (rs2_a_s == 5'd0) begin
            src2_val_s = 32'd0;
        end else if (FWD_EN && wb_hit2_s) begin
            src2_val_s = alu_res;
        end else begin
            src2_val_s = rf_q[rs2_a_s];
        end
    end

    // Operand B select and shift-amount masking
    always_comb begin
        opb_raw_s = 32'd0;
        opb_s     = 32'd0;
        if (dec_rtype_s) begin
            opb_raw_s = src2_val_s;
        end else begin
            opb_raw_s = imm_s;
        end
        if ((dec_sel_s == SEL_SLL) || (dec_sel_s == SEL_SRA)) begin
            opb_s = {27'd0, opb_raw_s[4:0]};
        end else begin
            opb_s = opb_raw_s;
        end
    end

    // EX next state: an accepted legal instruction, otherwise a bubble
    always_comb begin
        ex_a_d   = 32'd0;
        ex_b_d   = 32'd0;
        ex_sel_d = BUBBLE_SEL;
        ex_rd_d  = 5'd0;
        ex_we_d  = 1'b0;
        ill_d    = 1'b0;
        if (accept_s && dec_legal_s) begin
            ex_a_d   = src1_val_s;
            ex_b_d   = opb_s;
            ex_sel_d = dec_sel_s;
            ex_rd_d  = rd_s;
            ex_we_d  = (rd_s != 5'd0);
        end else begin
            ill_d = accept_s && !dec_legal_s;
        end
    end

    // WB next state follows EX by one cycle, aligned with the ALU result
    always_comb begin
        wb_valid_d = ex_we_q;
        wb_rd_d    = 5'd0;
        if (ex_we_q) begin
            wb_rd_d = ex_rd_q;
        end else begin
            wb_rd_d = 5'd0;
        end
    end

    // Pipeline registers for EX and WB
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_a_q     <= 32'd0;
            ex_b_q     <= 32'd0;
            ex_sel_q   <= BUBBLE_SEL;
            ex_rd_q    <= 5'd0;
            ex_we_q    <= 1'b0;
            ill_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= 5'd0;
        end else begin
            ex_a_q     <= ex_a_d;
            ex_b_q     <= ex_b_d;
            ex_sel_q   <= ex_sel_d;
            ex_rd_q    <= ex_rd_d;
            ex_we_q    <= ex_we_d;
            ill_q      <= ill_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
        end
    end

    // Register file; x0 is never targeted because wb_valid excludes rd=0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'd0;
            end
        end else if (wb_valid_q) begin
            rf_q[wb_rd_q] <= alu_res;
        end else begin
            rf_q[0] <= 32'd0;
        end
    end

    assign rs1_o    = ex_a_q;
    assign rs2_o    = ex_b_q;
    assign sel_o    = ex_sel_q;
    assign illegal  = ill_q;
    assign wb_valid = wb_valid_q;
    assign wb_rd    = wb_rd_q;
    assign wb_data  = wb_valid_q ? alu_res : 32'd0;

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: table of issue vectors, ISA-level scoreboard on writebacks,
// one instance with forwarding and one without.
module tb_alu_issue_wb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        in_valid_a, in_valid_b;
    logic        in_ready_a, in_ready_b;
    logic [31:0] rs1_a, rs2_a, rs1_b, rs2_b;
    logic [2:0]  sel_a, sel_b;
    logic [31:0] alu_res_a, alu_res_b;
    logic        wb_valid_a, wb_valid_b;
    logic [4:0]  wb_rd_a, wb_rd_b;
    logic [31:0] wb_data_a, wb_data_b;
    logic        illegal_a, illegal_b;

    always #5 clk = ~clk;

    alu_issue_wb #(.FWD_EN(1'b1), .BUBBLE_SEL(3'd7)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid_a), .in_ready(in_ready_a), .instr(instr),
        .rs1_o(rs1_a), .rs2_o(rs2_a), .sel_o(sel_a), .alu_res(alu_res_a),
        .wb_valid(wb_valid_a), .wb_rd(wb_rd_a), .wb_data(wb_data_a), .illegal(illegal_a)
    );

    alu_issue_wb #(.FWD_EN(1'b0), .BUBBLE_SEL(3'd7)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(in_ready_b), .instr(instr),
        .rs1_o(rs1_b), .rs2_o(rs2_b), .sel_o(sel_b), .alu_res(alu_res_b),
        .wb_valid(wb_valid_b), .wb_rd(wb_rd_b), .wb_data(wb_data_b), .illegal(illegal_b)
    );

    function automatic logic [31:0] alu_f(input logic [2:0] s, input logic [31:0] a, input logic [31:0] b);
        case (s)
            3'd0:    return a + b;
            3'd1:    return a & b;
            3'd2:    return a ^ b;
            3'd3:    return a << b[4:0];
            3'd4:    return $signed(a) >>> b[4:0];
            3'd5:    return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // Registered ALU model feeding both instances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_res_a <= 32'd0;
            alu_res_b <= 32'd0;
        end else begin
            alu_res_a <= alu_f(sel_a, rs1_a, rs2_a);
            alu_res_b <= alu_f(sel_b, rs1_b, rs2_b);
        end
    end

    typedef struct {
        bit          inst;
        logic [31:0] ins;
        int          stalls;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        bit          ill;
        int          gap;
        bit          rst_after;
    } vec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] d;
    } wb_t;

    vec_t        tbl[$];
    wb_t         sb[$];
    logic [31:0] m_rf [32];
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] r_t(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] i_t(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic vec_t mk(input bit inst, input logic [31:0] ins, input int st, input logic [2:0] sel,
                                input logic [31:0] a, input logic [31:0] b, input bit ill, input int gap,
                                input bit ra);
        vec_t v;
        v.inst = inst; v.ins = ins; v.stalls = st; v.sel = sel; v.a = a; v.b = b;
        v.ill = ill; v.gap = gap; v.rst_after = ra;
        return v;
    endfunction

    // Architectural model: executes in program order and queues the expected write
    task automatic iss(input logic [31:0] ins);
        logic [6:0]  opc, f7;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        isr, isi, ok;
        logic [31:0] a, b, r;
        opc = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
        isr = (opc == 7'b0110011);
        isi = (opc == 7'b0010011);
        a = m_rf[ins[19:15]];
        b = isr ? m_rf[ins[24:20]] : {{20{ins[31]}}, ins[31:20]};
        ok = 1'b0;
        r = 32'd0;
        if (isr || isi) begin
            case (f3)
                3'b000: if (isi || f7 == 7'h00) begin ok = 1'b1; r = a + b; end
                        else if (f7 == 7'h20) begin ok = 1'b1; r = a - b; end
                3'b111: if (isi || f7 == 7'h00) begin ok = 1'b1; r = a & b; end
                3'b100: if (isi || f7 == 7'h00) begin ok = 1'b1; r = a ^ b; end
                3'b001: if (f7 == 7'h00) begin ok = 1'b1; r = a << b[4:0]; end
                3'b101: if (f7 == 7'h20) begin ok = 1'b1; r = $signed(a) >>> b[4:0]; end
                default: ok = 1'b0;
            endcase
        end
        if (ok && rd != 5'd0) begin
            m_rf[rd] = r;
            sb.push_back('{rd, r});
        end
    endtask

    task automatic check_wb(input string who, input logic [4:0] rd, input logic [31:0] d);
        wb_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s_wb_unexpected: got rd=%0d data=%0h expected no write", who, rd, d);
        end else begin
            e = sb.pop_front();
            chk({who, "_wb_rd"}, {27'd0, rd}, {27'd0, e.rd});
            chk({who, "_wb_data"}, d, e.d);
        end
    endtask

    // Writeback monitor: every write must match the oldest queued expectation
    always @(negedge clk) begin
        if (!rst) begin
            if (wb_valid_a) check_wb("a", wb_rd_a, wb_data_a);
            if (wb_valid_b) check_wb("b", wb_rd_b, wb_data_b);
        end
    end

    task automatic reset_seq();
        @(negedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        @(negedge clk);
        chk("rst_wb_valid", {31'd0, wb_valid_a}, 32'd0);
        chk("rst_sel", {29'd0, sel_a}, 32'd7);
        chk("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input vec_t v);
        int   st;
        logic rdy;
        instr = v.ins;
        if (v.inst) in_valid_b = 1'b1; else in_valid_a = 1'b1;
        st = 0;
        @(negedge clk);
        rdy = v.inst ? in_ready_b : in_ready_a;
        while (!rdy && st < 6) begin
            st++;
            @(negedge clk);
            rdy = v.inst ? in_ready_b : in_ready_a;
        end
        if (!rdy) begin
            n_vec++;
            n_bad++;
            $display("FAIL accept_timeout: instr %08h still not accepted after %0d cycles", v.ins, st);
            in_valid_a = 1'b0;
            in_valid_b = 1'b0;
            return;
        end
        iss(v.ins);
        @(posedge clk);
        #1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        chk("stall_cycles", st, v.stalls);
        chk("sel_o", {29'd0, v.inst ? sel_b : sel_a}, {29'd0, v.sel});
        chk("rs1_o", v.inst ? rs1_b : rs1_a, v.a);
        chk("rs2_o", v.inst ? rs2_b : rs2_a, v.b);
        chk("illegal", {31'd0, v.inst ? illegal_b : illegal_a}, {31'd0, v.ill});
        if (v.rst_after) reset_seq();
        for (int g = 0; g < v.gap; g++) begin
            @(posedge clk);
            #1;
            if (g == 0) chk("bubble_sel", {29'd0, v.inst ? sel_b : sel_a}, 32'd7);
        end
    endtask

    initial begin
        // instance a (forwarding)
        tbl.push_back(mk(0, i_t(12'd5,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd5,        0, 3, 0));
        tbl.push_back(mk(0, i_t(12'hFFD, 5'd0, 3'b000, 5'd2), 0, 3'd0, 32'd0, 32'hFFFFFFFD, 0, 3, 0));
        tbl.push_back(mk(0, i_t(12'd9,   5'd0, 3'b000, 5'd0), 0, 3'd0, 32'd0, 32'd9,        0, 0, 0));
        tbl.push_back(mk(0, r_t(7'h00, 5'd0, 5'd0, 3'b000, 5'd8), 0, 3'd0, 32'd0, 32'd0,    0, 2, 0));
        tbl.push_back(mk(0, i_t(12'd7,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd7,        0, 0, 0));
        tbl.push_back(mk(0, r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd3), 1, 3'd0, 32'd7, 32'd7,    0, 3, 0));
        tbl.push_back(mk(0, i_t(12'd9,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd9,        0, 0, 0));
        tbl.push_back(mk(0, i_t(12'd0,   5'd0, 3'b000, 5'd5), 0, 3'd0, 32'd0, 32'd0,        0, 0, 0));
        tbl.push_back(mk(0, r_t(7'h20, 5'd0, 5'd1, 3'b000, 5'd4), 0, 3'd5, 32'd9, 32'd0,    0, 3, 0));
        tbl.push_back(mk(0, i_t(12'd1,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd1,        0, 0, 0));
        tbl.push_back(mk(0, i_t(12'h024, 5'd0, 3'b000, 5'd2), 0, 3'd0, 32'd0, 32'h24,       0, 3, 0));
        tbl.push_back(mk(0, r_t(7'h00, 5'd2, 5'd1, 3'b001, 5'd6), 0, 3'd3, 32'd1, 32'd4,    0, 3, 0));
        tbl.push_back(mk(0, i_t(12'hFF8, 5'd0, 3'b000, 5'd10), 0, 3'd0, 32'd0, 32'hFFFFFFF8, 0, 3, 0));
        tbl.push_back(mk(0, i_t(12'h41F, 5'd10, 3'b101, 5'd9), 0, 3'd4, 32'hFFFFFFF8, 32'd31, 0, 0, 0));
        tbl.push_back(mk(0, r_t(7'h20, 5'd1, 5'd10, 3'b101, 5'd11), 0, 3'd4, 32'hFFFFFFF8, 32'd1, 0, 0, 0));
        tbl.push_back(mk(0, i_t(12'h0F0, 5'd10, 3'b111, 5'd12), 0, 3'd1, 32'hFFFFFFF8, 32'hF0, 0, 0, 0));
        tbl.push_back(mk(0, r_t(7'h00, 5'd2, 5'd10, 3'b100, 5'd13), 0, 3'd2, 32'hFFFFFFF8, 32'h24, 0, 0, 0));
        tbl.push_back(mk(0, i_t(12'hFFF, 5'd0, 3'b100, 5'd14), 0, 3'd2, 32'd0, 32'hFFFFFFFF, 0, 0, 0));
        tbl.push_back(mk(0, i_t(12'h005, 5'd1, 3'b001, 5'd15), 0, 3'd3, 32'd1, 32'd5,      0, 3, 0));
        tbl.push_back(mk(0, i_t(12'd3,   5'd0, 3'b000, 5'd16), 0, 3'd0, 32'd0, 32'd3,       0, 0, 0));
        tbl.push_back(mk(0, i_t(12'd4,   5'd16, 3'b000, 5'd16), 1, 3'd0, 32'd3, 32'd4,      0, 0, 0));
        tbl.push_back(mk(0, r_t(7'h00, 5'd16, 5'd16, 3'b000, 5'd17), 1, 3'd0, 32'd7, 32'd7, 0, 3, 0));
        tbl.push_back(mk(0, 32'h0000006F, 0, 3'd7, 32'd0, 32'd0, 1, 0, 0));
        tbl.push_back(mk(0, r_t(7'h01, 5'd1, 5'd1, 3'b000, 5'd20), 0, 3'd7, 32'd0, 32'd0,  1, 0, 0));
        tbl.push_back(mk(0, i_t(12'd21,  5'd0, 3'b000, 5'd20), 0, 3'd0, 32'd0, 32'd21,      0, 0, 0));
        tbl.push_back(mk(0, i_t(12'h001, 5'd1, 3'b101, 5'd21), 0, 3'd7, 32'd0, 32'd0,      1, 0, 0));
        tbl.push_back(mk(0, i_t(12'd1,   5'd20, 3'b000, 5'd22), 0, 3'd0, 32'd21, 32'd1,     0, 3, 0));
        // reset while ADDI x1,x0,1 is in flight; x1 must then read 0
        tbl.push_back(mk(0, i_t(12'd1,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd1,        0, 0, 1));
        tbl.push_back(mk(0, r_t(7'h00, 5'd0, 5'd1, 3'b000, 5'd2), 0, 3'd0, 32'd0, 32'd0,    0, 4, 0));
        // instance b (no forwarding)
        tbl.push_back(mk(1, i_t(12'd9,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd9,        0, 0, 0));
        tbl.push_back(mk(1, i_t(12'd0,   5'd0, 3'b000, 5'd5), 0, 3'd0, 32'd0, 32'd0,        0, 0, 0));
        tbl.push_back(mk(1, r_t(7'h20, 5'd0, 5'd1, 3'b000, 5'd4), 1, 3'd5, 32'd9, 32'd0,    0, 3, 0));
        tbl.push_back(mk(1, i_t(12'd7,   5'd0, 3'b000, 5'd1), 0, 3'd0, 32'd0, 32'd7,        0, 0, 0));
        tbl.push_back(mk(1, r_t(7'h00, 5'd1, 5'd1, 3'b000, 5'd3), 2, 3'd0, 32'd7, 32'd7,    0, 4, 0));

        for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
        rst        = 1'b1;
        in_valid_a = 1'b0;
        in_valid_b = 1'b0;
        instr      = 32'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_in_ready", {31'd0, in_ready_a}, 32'd1);
        chk("reset_sel_o",    {29'd0, sel_a}, 32'd7);
        chk("reset_rs1_o",    rs1_a, 32'd0);
        chk("reset_rs2_o",    rs2_a, 32'd0);
        chk("reset_wb_valid", {31'd0, wb_valid_a}, 32'd0);
        chk("reset_wb_rd",    {27'd0, wb_rd_a}, 32'd0);
        chk("reset_wb_data",  wb_data_a, 32'd0);
        chk("reset_illegal",  {31'd0, illegal_a}, 32'd0);
        chk("reset_sel_o_b",  {29'd0, sel_b}, 32'd7);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (tbl[i]) issue(tbl[i]);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 32'd0);
        chk("illegal_idle", {31'd0, illegal_a}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_wb.md
Name: alu_issue_wb

Overview:
- Operand-issue and writeback stage wrapped around the registered ALU.
- Accepts RV32I R/I-type ALU instructions through a valid/ready handshake and decodes them to the ALU op select.
- Reads operands from an internal 32x32 register file, drives the ALU inputs from registers, and writes the ALU result back two cycles after issue.
- Detects RAW hazards against in-flight instructions and resolves them by stall or forwarding.

Parameters:
- FWD_EN, 1: 1 = forward alu_res to an instruction that depends on the one in WB; 0 = stall on that dependency too.
- BUBBLE_SEL, 3'd7: op select driven during bubbles; the ALU produces 0 for it.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  instr is valid
- in_ready  output  1  stage can accept instr this cycle
- instr  input  32  RV32I instruction word
- rs1_o  output  32  registered ALU operand A
- rs2_o  output  32  registered ALU operand B
- sel_o  output  3  registered ALU op select
- alu_res  input  32  ALU registered result (valid one cycle after rs1_o/rs2_o/sel_o)
- wb_valid  output  1  register-file write occurring this cycle
- wb_rd  output  5  destination of the write
- wb_data  output  32  data written (equals alu_res)
- illegal  output  1  one-cycle pulse: accepted instr not supported

Behaviour:
- Reset: asynchronous, active-high; clk is the only clock.
- Outputs at reset: rs1_o=0, rs2_o=0, sel_o=BUBBLE_SEL, wb_valid=0, wb_rd=0, wb_data=0, illegal=0, in_ready=1.
- Reset clears all 32 registers to 0 and all pipeline valid bits.
- Reset asserted mid-operation discards in-flight instructions; no writeback occurs afterwards.

Decode, R-type (opcode 0110011):
- ADD (f3=000, f7=0000000) -> sel 0
- SUB (f3=000, f7=0100000) -> sel 5
- AND (f3=111) -> sel 1
- XOR (f3=100) -> sel 2
- SLL (f3=001) -> sel 3
- SRA (f3=101, f7=0100000) -> sel 4

Decode, I-type (opcode 0010011):
- ADDI, ANDI, XORI, SLLI, SRAI with the same sel values as the R-type forms.
- SRAI requires imm[11:5]=0100000; SLLI requires imm[11:5]=0.
- Operand B is sign-extended imm[11:0].

Shift operand masking:
- For sel 3 and 4, rs2_o carries only the shift amount zero-extended from bits [4:0].
- R-type uses rs2[4:0]; I-type uses shamt.

Illegal instructions:
- Any other encoding is illegal.
- It is still accepted (handshake completes) and pulses illegal the next cycle.
- The EX slot becomes a bubble: sel_o=BUBBLE_SEL, operands 0, no writeback.

Pipeline timing:
- Accept at edge E0 (in_valid & in_ready).
- Operands, sel_o and ex_rd/ex_we are registered at E0.
- The ALU registers its result at E1.
- At cycle E1..E2, alu_res is valid: wb_valid=1, wb_rd, wb_data=alu_res combinationally, regfile written at E2.
- Latency from issue to architectural write: 2 edges.
- No write when rd=x0. x0 always reads 0 and is never forwarded.

Bubbles:
- No accept on an edge -> EX loads a bubble (sel_o=BUBBLE_SEL, rs1_o=rs2_o=0, ex_we=0).
- Operands are not held, because the ALU recomputes every cycle.

Hazards (source = rs1, and rs2 for R-type; x0 excluded):
- Source equals ex_rd with ex_we: in_ready=0 for that cycle (1-cycle stall).
- Source equals wb_rd with wb_valid:
  - FWD_EN=1: operand taken from alu_res, no stall.
  - FWD_EN=0: in_ready=0 until the write completes.
- Both EX and WB match the same register: EX match dominates (stall).
- After the stall, WB then holds the newer value and it is forwarded.
- Simultaneous write and read of the same register in one cycle: the forwarded/new value is used, never the stale regfile value.

Handshake:
- in_ready depends only on the hazard check and is combinational from instr/pipeline state.
- instr must be held stable while in_valid=1 and in_ready=0.
- in_valid=0 never stalls.

Test Plan:
- Reset, then ADDI x1,x0,5 / ADDI x2,x0,-3 with gaps -> sel_o=0; at E2 wb_rd=1 wb_data=5; then wb_rd=2 wb_data=0xFFFFFFFD; x0 stays 0.
- ADDI x1,x0,7 immediately followed by ADD x3,x1,x1 -> in_ready=0 exactly one cycle; ADD issues with rs1_o=rs2_o=7; wb_data=14 to x3.
- One independent instruction between producer and consumer (FWD_EN=1): x1=9, NOP-class ADDI x5,x0,0, SUB x4,x1,x0 -> no stall; rs1_o=9 via forward; x4=9. Same with FWD_EN=0 -> one stall cycle, same result.
- SLL x6,x1,x2 with x1=1, x2=0x00000024 -> rs2_o=4, sel_o=3; x6=0x10. SRAI imm[11:5]=0100000 shamt=31 -> sel 4, rs2_o=31.
- instr=0x0000006F (JAL) -> accepted, illegal=1 one cycle, sel_o=7, no wb_valid; following ADDI still executes normally.
- Assert rst one cycle after issuing ADDI x1,x0,1 -> wb_valid never asserts; after release x1 reads 0 (ADD x2,x1,x0 writes 0).
